// File: rtl/shift_seq.sv
// shift_seq: multi-cycle barrel-free shifter (SLL / SRL / SRA).
// A request is latched in IDLE, then the working register is shifted a few
// bits per cycle until the latched count is used up, and the final value is
// presented for exactly one cycle with done=1.
// Optional build macro: SHIFT_SEQ_FAST_STEP_EN -- when defined, each SHIFT
// cycle consumes four bits of count while at least four remain, otherwise one.
module shift_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [31:0]      shamt,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [4:0]       cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] result_q;

    logic [4:0]       step;
    logic [4:0]       cnt_after;
    logic [WIDTH-1:0] work_shifted;

    // Only the low five bits of the shift amount are meaningful.
    logic shamt_unused;
    assign shamt_unused = &{1'b0, shamt[31:5]};

    // Step size for the current SHIFT cycle and the count left after it.
    always_comb begin
`ifdef SHIFT_SEQ_FAST_STEP_EN
        step = (cnt >= 5'd4) ? 5'd4 : 5'd1;
`else
        step = 5'd1;
`endif
        cnt_after = cnt - step;
    end

    // One shift step of the working register; SRA keeps the latched sign bit
    // because the arithmetic shift re-copies work[WIDTH-1] every step.
    always_comb begin
        case (op_q)
            OP_SLL:  work_shifted = work << step;
            OP_SRA:  work_shifted = $unsigned($signed(work) >>> step);
            default: work_shifted = work >> step;   // SRL and the 11 encoding
        endcase
    end

    // Control FSM plus operand/result registers; result is only written on
    // the edge that enters DONE so it holds through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            work     <= '0;
            cnt      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work <= data_in;
                        op_q <= op;
                        cnt  <= shamt[4:0];
                        if (shamt[4:0] == 5'd0) begin
                            state    <= DONE;
                            result_q <= data_in;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= work_shifted;
                    cnt  <= cnt_after;
                    if (cnt_after == 5'd0) begin
                        state    <= DONE;
                        result_q <= work_shifted;
                    end
                end
                DONE: begin
                    // start is deliberately ignored here.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed bench for shift_seq with a transaction-level model
// (whole-amount shift + latency formula) compared every cycle, plus literal
// expectations for results and done latency.
module tb_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] shamt;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

`ifdef SHIFT_SEQ_FAST_STEP_EN
    localparam int L31 = 11, L4 = 2, L8 = 3, L3 = 4, L13 = 5, L5 = 3, L2 = 3;
`else
    localparam int L31 = 32, L4 = 5, L8 = 9, L3 = 4, L13 = 14, L5 = 6, L2 = 3;
`endif
    localparam int L1 = 2;
    localparam int L0 = 1;

    shift_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .shamt   (shamt),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: the whole shift in one operation.
    function automatic logic [31:0] model_shift(input logic [1:0] o, input logic [4:0] k,
                                                input logic [31:0] d);
        case (o)
            2'b00:   return d << k;
            2'b10:   return $unsigned($signed(d) >>> k);
            default: return d >> k;
        endcase
    endfunction

    // Reference: cycles from the accepting edge to the done cycle.
    function automatic int model_latency(input logic [4:0] k);
        int kk;
        kk = int'(k);
        if (kk == 0) return 1;
`ifdef SHIFT_SEQ_FAST_STEP_EN
        return kk / 4 + kk % 4 + 1;
`else
        return kk + 1;
`endif
    endfunction

    logic        m_busy;
    logic        m_done;
    logic [31:0] m_result;
    logic [31:0] m_pending;
    int          m_left;

    // Transaction model: accept, count down the latency, then one done cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            m_result  <= '0;
            m_pending <= '0;
            m_left    <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy    <= 1'b1;
                m_pending <= model_shift(op, shamt[4:0], data_in);
                if (model_latency(shamt[4:0]) == 1) begin
                    m_done   <= 1'b1;
                    m_result <= model_shift(op, shamt[4:0], data_in);
                end else begin
                    m_left <= model_latency(shamt[4:0]) - 1;
                end
            end
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done   <= 1'b1;
                m_result <= m_pending;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("cyc_busy",   {31'b0, busy}, {31'b0, m_busy});
        check("cyc_done",   {31'b0, done}, {31'b0, m_done});
        check("cyc_result", result, m_result);
    end

    // Count done pulses.
    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
    end

    // Issue one request, scramble inputs after acceptance, wait for done.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] s,
                          input logic [31:0] d, input logic [31:0] exp_res, input int exp_lat);
        int n;
        @(negedge clk);
        op = o; shamt = s; data_in = d; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = ~o; shamt = ~s; data_in = ~d;
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        $display("txn %s op=%0d shamt=0x%08h data=0x%08h -> result=0x%08h latency=%0d",
                 name, o, s, d, result, n);
        check({name, "_latency"}, n, exp_lat);
        check({name, "_result"}, result, exp_res);
    endtask

    initial begin
        int n;
        int d0;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; shamt = '0; data_in = '0;
        #1;
        check("reset_busy",   {31'b0, busy}, 32'd0);
        check("reset_done",   {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("sll31",  2'b00, 32'h0000001F, 32'h00000001, 32'h80000000, L31);
        run_op("sra4",   2'b10, 32'h00000004, 32'h80000000, 32'hF8000000, L4);
        run_op("srl32",  2'b01, 32'h00000020, 32'h12345678, 32'h12345678, L0);
        run_op("op11",   2'b11, 32'h00000003, 32'h80000001, 32'h10000000, L3);
        run_op("sra13",  2'b10, 32'h0000000D, 32'hF0F0F0F0, 32'hFFFF8787, L13);
        run_op("srlhi",  2'b01, 32'hFFFFFFE5, 32'h80000000, 32'h04000000, L5);
        run_op("sra0",   2'b10, 32'h00000000, 32'h80000000, 32'h80000000, L0);

        // Second start pulsed during SHIFT and in the DONE cycle.
        @(negedge clk);
        op = 2'b01; shamt = 32'd8; data_in = 32'hFFFF0000; start = 1'b1;
        @(posedge clk);
        d0 = done_count;
        @(negedge clk);
        op = 2'b00; shamt = 32'd1; data_in = 32'h55555555; start = 1'b1;
        n = 1;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        $display("txn ignore_start srl8 -> result=0x%08h latency=%0d", result, n);
        check("ign_latency", n, L8);
        check("ign_result", result, 32'h00FFFF00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("ign_pulses", done_count - d0, 32'd1);
        check("ign_busy", {31'b0, busy}, 32'd0);
        check("ign_hold", result, 32'h00FFFF00);

        // Back-to-back with start held high in IDLE.
        @(negedge clk);
        op = 2'b10; shamt = 32'd1; data_in = 32'h80000000; start = 1'b1;
        @(posedge clk);
        d0 = done_count;
        @(negedge clk);
        op = 2'b00; shamt = 32'd2; data_in = 32'h00000003;
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        $display("txn b2b_first sra1 -> result=0x%08h latency=%0d", result, n);
        check("b2b1_latency", n, L1);
        check("b2b1_result", result, 32'hC0000000);
        @(negedge clk);
        check("b2b_idle_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        $display("txn b2b_second sll2 -> result=0x%08h latency=%0d", result, n);
        check("b2b2_latency", n, L2);
        check("b2b2_result", result, 32'h0000000C);
        @(negedge clk);
        #1;
        check("b2b_pulses", done_count - d0, 32'd2);

        // Reset in the middle of a SHIFT.
        @(negedge clk);
        op = 2'b00; shamt = 32'd20; data_in = 32'h0000000F; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy_before", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn midreset -> busy=%0d done=%0d result=0x%08h", busy, done, result);
        check("mid_rst_busy",   {31'b0, busy}, 32'd0);
        check("mid_rst_done",   {31'b0, done}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        d0 = done_count;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("mid_no_done", done_count - d0, 32'd0);

        run_op("after_rst", 2'b01, 32'h00000020, 32'h12345678, 32'h12345678, L0);
        run_op("sll1",      2'b00, 32'h00000001, 32'h40000001, 32'h80000002, L1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of data_in and result.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin a shift; sampled on rising clk.
REQ-005 The block SHALL have port op  input  2  shift type: 00 SLL, 01 SRL, 10 SRA, 11 treated as SRL.
REQ-006 The block SHALL have port shamt  input  32  zero-extended shift amount; only bits [4:0] used, bits [31:5] ignored.
REQ-007 The block SHALL have port data_in  input  WIDTH  operand to be shifted.
REQ-008 The block SHALL have port busy  output  1  high while a request is in progress (states SHIFT and DONE).
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 The block SHALL have port result  output  WIDTH  shifted value; held until the next accepted start.

Function
REQ-011 The block SHALL implement states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch data_in, op and cnt=shamt[4:0] into internal registers.
REQ-013 On that accepting edge, the block SHALL go to DONE if cnt=0, else to SHIFT.
REQ-014 In SHIFT, each cycle SHALL shift the working register by one bit and decrement cnt by one.
REQ-015 SLL SHALL fill with 0; SRL SHALL fill with 0; SRA SHALL replicate the bit latched at position WIDTH-1.
REQ-016 The block SHALL move SHIFT->DONE on the edge where the step consumes the last remaining count (cnt reaches 0).
REQ-017 In DONE, done SHALL be 1 and result SHALL equal the working register; the next edge SHALL return to IDLE.
REQ-018 Latency from the accepting edge to the done cycle SHALL be k+1 cycles for k=shamt[4:0]>0, and 1 cycle for k=0.
REQ-019 start SHALL be ignored while busy=1, including start in the DONE cycle; inputs then have no effect.
REQ-020 busy SHALL be 0 in IDLE and SHALL fall on the same edge that done falls.
REQ-021 result SHALL be updated only on entry to DONE and SHALL hold its value through IDLE until the next DONE.
REQ-022 Changes to op, shamt or data_in after the accepting edge SHALL NOT affect the in-flight result.

Reset
REQ-023 While rst_n=0, the block SHALL force state=IDLE, busy=0, done=0, result=0, cnt=0 and working register=0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL abort the request with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-025 With macro SHIFT_SEQ_FAST_STEP_EN defined, each SHIFT cycle SHALL shift by 4 and subtract 4 when cnt>=4; otherwise it SHALL shift by 1 and subtract 1.
REQ-026 With SHIFT_SEQ_FAST_STEP_EN defined, latency SHALL be floor(k/4)+(k mod 4)+1 cycles for k>0, and 1 cycle for k=0.
REQ-027 Without SHIFT_SEQ_FAST_STEP_EN, the block SHALL use only single-bit steps per REQ-014/REQ-018; the interface SHALL be identical in both builds.

Verification
REQ-028 SLL, data_in=0x00000001, shamt=0x0000001F -> result=0x80000000; done 32 cycles after accept (11 with macro).
REQ-029 SRA, data_in=0x80000000, shamt=0x00000004 -> result=0xF8000000; done after 5 cycles (2 with macro).
REQ-030 SRL, data_in=0x12345678, shamt=0x00000020 (bits[4:0]=0) -> result=0x12345678; done 1 cycle after accept.
REQ-031 SRL, data_in=0xFFFF0000, shamt=8, with a second start (SLL, shamt=1) pulsed during SHIFT and in DONE -> result=0x00FFFF00, one done pulse, second start ignored.
REQ-032 rst_n pulsed low during SHIFT of an SLL with shamt=20 -> busy=0, done=0, result=0 immediately; no done pulse follows.
REQ-033 Back-to-back: SRA 0x80000000 by 1 then, start held high in IDLE, SLL 0x00000003 by 2 -> results 0xC0000000 then 0x0000000C, two done pulses.
